// File: rtl/mem_lsu_if.sv
// Core-side request/response and memory-side command/data signals of the load/store unit.
// Names are from the LSU's point of view; slave is the LSU, master is the core plus memory.
interface mem_lsu_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [31:0] i_req_addr;
   logic [2:0]  i_req_size;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_mem_en;
   logic        o_mem_write_en;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_mask;
   logic [31:0] o_mem_data;
   logic        i_mem_ready;
   logic        i_mem_valid;
   logic [31:0] i_mem_data;

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_wdata,
      input  i_rsp_ready, i_mem_ready, i_mem_valid, i_mem_data,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
      output o_mem_en, o_mem_write_en, o_mem_addr, o_mem_mask, o_mem_data
   );

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_wdata,
      output i_rsp_ready, i_mem_ready, i_mem_valid, i_mem_data,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
      input  o_mem_en, o_mem_write_en, o_mem_addr, o_mem_mask, o_mem_data
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: converts sized byte-addressed core accesses into word-index plus lane-mask
// memory commands, aligns/extends load data, and rejects bad accesses without touching memory.
module mem_lsu #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic      i_clk,
   input  logic      i_rst,
   mem_lsu_if.slave  bus
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

   state_t       r_state, w_nextState;
   logic [31:0]  r_addr;
   logic [2:0]   r_size;
   logic         r_we;
   logic [3:0]   r_memMask;
   logic [31:0]  r_memData;
   logic [31:0]  r_rdata;
   logic         r_err;
   logic [CW-1:0] r_count;

   logic         w_illegal, w_misalign, w_reqBad, w_timeout;
   logic [3:0]   w_reqMask;
   logic [31:0]  w_reqData, w_shifted, w_loadData;

   // Request classification and lane placement are computed from the live request so the
   // command can be registered in the accept cycle and held unchanged through ISSUE.
   always_comb begin
      w_illegal  = (bus.i_req_size[1:0] == 2'd3) ||
                   (bus.i_req_size[2] && (bus.i_req_we || bus.i_req_size[1:0] == 2'd2));
      w_misalign = ((bus.i_req_size[1:0] == 2'd1) && bus.i_req_addr[0]) ||
                   ((bus.i_req_size[1:0] == 2'd2) && (bus.i_req_addr[1:0] != 2'd0));
      w_reqBad   = w_illegal || w_misalign;
      w_reqMask  = 4'b0000;
      w_reqData  = 32'd0;
      case (bus.i_req_size[1:0])
         2'd0: begin
            w_reqMask = 4'b0001 << bus.i_req_addr[1:0];
            w_reqData = {4{bus.i_req_wdata[7:0]}};
         end
         2'd1: begin
            w_reqMask = 4'b0011 << bus.i_req_addr[1:0];
            w_reqData = {2{bus.i_req_wdata[15:0]}};
         end
         2'd2: begin
            w_reqMask = 4'b1111;
            w_reqData = bus.i_req_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_shifted  = bus.i_mem_data >> {r_addr[1:0], 3'b000};
      w_loadData = w_shifted;
      case (r_size[1:0])
         2'd0:    w_loadData = {{24{w_shifted[7] & ~r_size[2]}}, w_shifted[7:0]};
         2'd1:    w_loadData = {{16{w_shifted[15] & ~r_size[2]}}, w_shifted[15:0]};
         default: w_loadData = w_shifted;
      endcase
      w_timeout = (r_count == CW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState        = r_state;
      bus.o_req_ready    = 1'b0;
      bus.o_mem_en       = 1'b0;
      bus.o_mem_write_en = 1'b0;
      bus.o_rsp_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            bus.o_req_ready = 1'b1;
            if (bus.i_req_valid) w_nextState = w_reqBad ? RESP : ISSUE;
         end
         ISSUE: begin
            bus.o_mem_en       = 1'b1;
            bus.o_mem_write_en = r_we;
            if (bus.i_mem_ready) w_nextState = r_we ? RESP : RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.i_mem_valid || w_timeout) w_nextState = RESP;
         end
         RESP: begin
            bus.o_rsp_valid = 1'b1;
            if (bus.i_rsp_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // A read completing on the last allowed cycle still returns its data rather than an error.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr    <= 32'd0;
         r_size    <= 3'd0;
         r_we      <= 1'b0;
         r_memMask <= 4'd0;
         r_memData <= 32'd0;
         r_rdata   <= 32'd0;
         r_err     <= 1'b0;
         r_count   <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.i_req_valid) begin
               r_addr    <= bus.i_req_addr;
               r_size    <= bus.i_req_size;
               r_we      <= bus.i_req_we;
               r_memMask <= w_reqMask;
               r_memData <= w_reqData;
               r_rdata   <= 32'd0;
               r_err     <= w_reqBad;
            end
            ISSUE: r_count <= '0;
            RD_WAIT: begin
               if (bus.i_mem_valid) begin
                  r_rdata <= w_loadData;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata <= 32'd0;
                  r_err   <= 1'b1;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_mem_addr  = {2'b00, r_addr[31:2]};
   assign bus.o_mem_mask  = r_memMask;
   assign bus.o_mem_data  = r_memData;
   assign bus.o_rsp_rdata = r_rdata;
   assign bus.o_rsp_err   = r_err;

endmodule
